branch_update_queue: RTL and testbench

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

---
 rtl/bp_pkg.sv | 19 +
 rtl/branch_update_stats.sv | 26 ++
 rtl/branch_update_queue.sv | 119 +++++++++++
 tb/tb_branch_update_queue.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the branch update queue: per-entry record and tag-width helper.
package bp_pkg;

  // Entry PC storage is sized for the widest supported PC; narrower PCs are zero-extended.
  localparam int unsigned BP_PC_MAX = 64;

  typedef struct packed {
    logic                 valid;
    logic                 resolved;
    logic [BP_PC_MAX-1:0] pc;
    logic                 pred;
    logic                 actual;
  } bq_entry_t;

  function automatic int unsigned bp_tag_bits(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/branch_update_stats.sv
// Saturating retire/mispredict counters for the branch update queue.
// Present only when BUQ_STATS_EN is defined.
`ifdef BUQ_STATS_EN
module branch_update_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        mispredict,
  output logic [15:0] stat_retired,
  output logic [15:0] stat_mispredict
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_retired    <= '0;
      stat_mispredict <= '0;
    end else begin
      if (wr_en && (stat_retired != '1))
        stat_retired <= stat_retired + 16'd1;
      if (mispredict && (stat_mispredict != '1))
        stat_mispredict <= stat_mispredict + 16'd1;
    end
  end

endmodule
`endif

// File: rtl/branch_update_queue.sv
// In-order branch update queue: allocate at fetch, resolve out of order, retire in order.
// Optional statistics counters are enabled with macro BUQ_STATS_EN.
module branch_update_queue
  import bp_pkg::*;
#(
  parameter  int unsigned PC_BITS = 32,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned TAG_W   = bp_tag_bits(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_valid,
  input  logic [PC_BITS-1:0] alloc_pc,
  input  logic               alloc_pred_taken,
  output logic               alloc_ready,
  output logic [TAG_W-1:0]   alloc_tag,
  input  logic               resolve_valid,
  input  logic [TAG_W-1:0]   resolve_tag,
  input  logic               resolve_taken,
  input  logic               flush,
  output logic               Wr_En,
  output logic [PC_BITS-1:0] Orig_PC,
  output logic               is_Taken,
  output logic               mispredict
`ifdef BUQ_STATS_EN
  ,
  output logic [15:0]        stat_retired,
  output logic [15:0]        stat_mispredict
`endif
);

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);

  bq_entry_t        entries [DEPTH];
  logic [TAG_W:0]   head;
  logic [TAG_W:0]   tail;
  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  logic             alloc_fire;
  logic             resolve_fire;
  logic             retire;
  bq_entry_t        head_e;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  // Same index with differing wrap bits means the tail has lapped the head.
  assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

  assign alloc_ready  = ~full;
  assign alloc_tag    = tail_idx;
  assign alloc_fire   = alloc_valid && !full;
  assign resolve_fire = resolve_valid && entries[resolve_tag].valid &&
                        !entries[resolve_tag].resolved;

  assign head_e = entries[head_idx];
  assign retire = head_e.valid && head_e.resolved && !flush;

  always_comb begin
    Wr_En      = 1'b0;
    Orig_PC    = '0;
    is_Taken   = 1'b0;
    mispredict = 1'b0;
    if (retire) begin
      Wr_En      = 1'b1;
      Orig_PC    = PC_BITS'(head_e.pc);
      is_Taken   = head_e.actual;
      mispredict = head_e.pred ^ head_e.actual;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        entries[i] <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i].valid    <= 1'b0;
        entries[i].resolved <= 1'b0;
      end
      head <= '0;
      tail <= '0;
    end else begin
      if (retire) begin
        entries[head_idx].valid    <= 1'b0;
        entries[head_idx].resolved <= 1'b0;
        head                       <= head + PTR_ONE;
      end
      // Resolve targets only entries valid before this edge, so it never hits the head being
      // retired (already resolved) nor the slot being allocated (still invalid).
      if (resolve_fire) begin
        entries[resolve_tag].resolved <= 1'b1;
        entries[resolve_tag].actual   <= resolve_taken;
      end
      if (alloc_fire) begin
        entries[tail_idx] <= '{valid:    1'b1,
                               resolved: 1'b0,
                               pc:       BP_PC_MAX'(alloc_pc),
                               pred:     alloc_pred_taken,
                               actual:   1'b0};
        tail              <= tail + PTR_ONE;
      end
    end
  end

`ifdef BUQ_STATS_EN
  branch_update_stats u_stats (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (Wr_En),
    .mispredict      (mispredict),
    .stat_retired    (stat_retired),
    .stat_mispredict (stat_mispredict)
  );
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized and directed bench for branch_update_queue against an in-order queue model.
module tb_branch_update_queue;

  localparam int unsigned PC_BITS = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TW      = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               alloc_valid;
  logic [PC_BITS-1:0] alloc_pc;
  logic               alloc_pred_taken;
  logic               alloc_ready;
  logic [TW-1:0]      alloc_tag;
  logic               resolve_valid;
  logic [TW-1:0]      resolve_tag;
  logic               resolve_taken;
  logic               flush;
  logic               Wr_En;
  logic [PC_BITS-1:0] Orig_PC;
  logic               is_Taken;
  logic               mispredict;

  always #5 clk = ~clk;

  branch_update_queue #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_valid      (alloc_valid),
    .alloc_pc         (alloc_pc),
    .alloc_pred_taken (alloc_pred_taken),
    .alloc_ready      (alloc_ready),
    .alloc_tag        (alloc_tag),
    .resolve_valid    (resolve_valid),
    .resolve_tag      (resolve_tag),
    .resolve_taken    (resolve_taken),
    .flush            (flush),
    .Wr_En            (Wr_En),
    .Orig_PC          (Orig_PC),
    .is_Taken         (is_Taken),
    .mispredict       (mispredict)
  );

  // Model: program-ordered list of in-flight branches, oldest first.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        pred;
    logic        resolved;
    logic        actual;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Compare every DUT output with what the model says for the current inputs.
  task automatic check_model();
    logic        wr;
    logic [31:0] pc;
    logic        tk;
    logic        mp;
    wr = (q.size() > 0) && q[0].resolved && !flush;
    pc = wr ? q[0].pc : 32'h0;
    tk = wr ? q[0].actual : 1'b0;
    mp = wr ? (q[0].pred != q[0].actual) : 1'b0;
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
    chk("alloc_tag",   32'(alloc_tag),   32'(next_tag));
    chk("wr_en",       32'(Wr_En),       32'(wr));
    chk("orig_pc",     Orig_PC,          pc);
    chk("is_taken",    32'(is_Taken),    32'(tk));
    chk("mispredict",  32'(mispredict),  32'(mp));
  endtask

  task automatic model_edge(input logic av, input logic [31:0] apc, input logic ap,
                            input logic rv, input int rt, input logic rtk, input logic fl);
    bit was_full;
    bit ret;
    if (fl) begin
      q.delete();
      next_tag = 0;
      return;
    end
    was_full = (q.size() == DEPTH);
    ret      = (q.size() > 0) && q[0].resolved;
    if (rv) begin
      foreach (q[i]) begin
        if (q[i].tag == rt && !q[i].resolved) begin
          q[i].resolved = 1'b1;
          q[i].actual   = rtk;
        end
      end
    end
    if (ret) void'(q.pop_front());
    if (av && !was_full) begin
      q.push_back('{tag: next_tag, pc: apc, pred: ap, resolved: 1'b0, actual: 1'b0});
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  task automatic drive(input logic av, input logic [31:0] apc, input logic ap,
                       input logic rv, input int rt, input logic rtk, input logic fl);
    alloc_valid      = av;
    alloc_pc         = apc;
    alloc_pred_taken = ap;
    resolve_valid    = rv;
    resolve_tag      = TW'(rt);
    resolve_taken    = rtk;
    flush            = fl;
  endtask

  // One cycle: drive, check against model, take the edge, advance the model.
  task automatic step(input logic av, input logic [31:0] apc, input logic ap,
                      input logic rv, input int rt, input logic rtk, input logic fl);
    drive(av, apc, ap, rv, rt, rtk, fl);
    #2;
    check_model();
    @(posedge clk);
    model_edge(av, apc, ap, rv, rt, rtk, fl);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic pred);
    step(1'b1, pc, pred, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_resolve(input int tag, input logic taken);
    step(1'b0, 32'h0, 1'b0, 1'b1, tag, taken, 1'b0);
  endtask

  task automatic do_flush();
    step(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic peek_idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #3;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag",   32'(alloc_tag),   32'd0);
    chk("rst_wr_en",       32'(Wr_En),       32'd0);
    chk("rst_orig_pc",     Orig_PC,          32'h0);
    chk("rst_mispredict",  32'(mispredict),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single branch, correctly predicted.
    do_alloc(32'h100, 1'b1);
    do_resolve(0, 1'b1);
    peek_idle();
    chk("s1_wr_en",      32'(Wr_En),      32'd1);
    chk("s1_orig_pc",    Orig_PC,         32'h100);
    chk("s1_is_taken",   32'(is_Taken),   32'd1);
    chk("s1_mispredict", 32'(mispredict), 32'd0);
    idle();

    // Out-of-order resolve, in-order retire.
    do_flush();
    do_alloc(32'h200, 1'b0);
    do_alloc(32'h204, 1'b1);
    do_resolve(1, 1'b1);
    peek_idle();
    chk("s2_wait_wr_en", 32'(Wr_En), 32'd0);
    do_resolve(0, 1'b0);
    peek_idle();
    chk("s2_first_wr",  32'(Wr_En), 32'd1);
    chk("s2_first_pc",  Orig_PC,    32'h200);
    idle();
    peek_idle();
    chk("s2_second_wr", 32'(Wr_En), 32'd1);
    chk("s2_second_pc", Orig_PC,    32'h204);
    idle();

    // Fill, drop when full, no same-cycle bypass on retire, tag wrap.
    do_flush();
    for (int i = 0; i < 8; i++) do_alloc(32'h300 + 32'(4 * i), 1'b1);
    peek_idle();
    chk("s3_full_ready", 32'(alloc_ready), 32'd0);
    chk("s3_full_tag",   32'(alloc_tag),   32'd0);
    do_alloc(32'hDEAD, 1'b0);
    do_resolve(0, 1'b1);
    drive(1'b1, 32'hBEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #2;
    chk("s3_retire_wr",    32'(Wr_En),       32'd1);
    chk("s3_retire_ready", 32'(alloc_ready), 32'd0);
    step(1'b1, 32'hBEEF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    peek_idle();
    chk("s3_after_ready", 32'(alloc_ready), 32'd1);
    chk("s3_after_tag",   32'(alloc_tag),   32'd0);
    idle();

    // Mispredict pulse.
    do_flush();
    do_alloc(32'h400, 1'b0);
    do_resolve(0, 1'b1);
    peek_idle();
    chk("s4_mispredict", 32'(mispredict), 32'd1);
    chk("s4_wr_en",      32'(Wr_En),      32'd1);
    chk("s4_is_taken",   32'(is_Taken),   32'd1);
    idle();
    peek_idle();
    chk("s4_pulse_end", 32'(mispredict), 32'd0);

    // Flush with a resolved head, then stale resolves.
    do_flush();
    do_alloc(32'h500, 1'b1);
    do_alloc(32'h504, 1'b1);
    do_alloc(32'h508, 1'b1);
    do_resolve(0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    #2;
    chk("s5_flush_wr",  32'(Wr_En),      32'd0);
    chk("s5_flush_mp",  32'(mispredict), 32'd0);
    do_flush();
    peek_idle();
    chk("s5_tag",   32'(alloc_tag),   32'd0);
    chk("s5_ready", 32'(alloc_ready), 32'd1);
    do_resolve(1, 1'b1);
    do_resolve(0, 1'b1);
    peek_idle();
    chk("s5_stale_wr", 32'(Wr_En), 32'd0);
    idle();

    // Asynchronous reset between edges with a resolved head.
    do_alloc(32'h600, 1'b1);
    do_resolve(0, 1'b1);
    peek_idle();
    chk("s6_pre_wr", 32'(Wr_En), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("s6_rst_wr",    32'(Wr_En),       32'd0);
    chk("s6_rst_pc",    Orig_PC,          32'h0);
    chk("s6_rst_ready", 32'(alloc_ready), 32'd1);
    chk("s6_rst_tag",   32'(alloc_tag),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    next_tag = 0;
    for (int i = 0; i < 3; i++) idle();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic        av, ap, rv, rtk, fl;
      logic [31:0] apc;
      int          rt;
      av  = 1'($urandom_range(0, 1));
      ap  = 1'($urandom_range(0, 1));
      apc = $urandom();
      rv  = ($urandom_range(0, 9) < 6);
      rtk = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 59) == 0);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        rt = q[$urandom_range(0, q.size() - 1)].tag;
      else
        rt = int'($urandom_range(0, DEPTH - 1));
      step(av, apc, ap, rv, rt, rtk, fl);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
